hex_word_entry: RTL



---
 rtl/hex_entry_pkg.sv | 33 +++
 rtl/hex_word_entry_if.sv | 11 +
 rtl/key_debounce.sv | 65 ++++++
 rtl/hex_word_entry.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the hex word entry block.
// The word is four hex digits; the first digit only contributes two bits.
package hex_entry_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    OFFER = 2'd3
  } state_e;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int WORD_BITS  = 14;
  localparam logic [DIGIT_W-1:0] TOP_DIGIT_MAX = 4'd3;

  // Shift a new digit in at the bottom; older digits move toward the MSBs.
  function automatic logic [WORD_BITS-1:0] append_digit(
    input logic [WORD_BITS-1:0] word,
    input logic [DIGIT_W-1:0]   digit
  );
    return {word[WORD_BITS-DIGIT_W-1:0], digit};
  endfunction

  // The very first digit lands in the 2-bit top position, so it must fit there.
  function automatic logic top_digit_reject(
    input logic [2:0]         count,
    input logic [DIGIT_W-1:0] digit
  );
    return (count == 3'd0) && (digit > TOP_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/hex_word_entry_if.sv
// Valid/ready handshake carrying the committed 14-bit word to the datapath.
interface hex_word_entry_if;
  import hex_entry_pkg::*;

  logic [WORD_BITS-1:0] word_out;
  logic                 word_valid;
  logic                 word_ready;

  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);
endinterface

// File: rtl/key_debounce.sv
// Button conditioning: 2-flop synchronizer, stable-sample debounce counter,
// and a one-cycle pulse on the accepted press (1->0) transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Synchronizer flops idle at the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync_q  <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync_q  <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = {CNT_W{1'b0}};
    press_d = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
        cnt_d   = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
    press_d = level_q & ~level_d;
  end

  // Debounce state and press pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      cnt_q   <= {CNT_W{1'b0}};
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/hex_word_entry.sv
// Builds a 14-bit word one hex digit per ENTER press, then offers it over a
// valid/ready handshake; the partial word is exported for display echo.
module hex_word_entry
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WORD_W          = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIGIT_W-1:0]   digit_in,
  input  logic                 key_enter_n,
  input  logic                 key_clear_n,
  hex_word_entry_if.master     word_if,
  output logic [WORD_W-1:0]    entry_value,
  output logic [2:0]           digit_count,
  output logic                 entry_error
);

  logic        enter_p;
  logic        clear_p;
  logic        reject_s;
  state_e      state_q, state_d;
  logic [WORD_W-1:0] entry_q, entry_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [2:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_enter_n),
    .press (enter_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_clear_n),
    .press (clear_p)
  );

  assign reject_s = top_digit_reject(count_q, digit_in);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; CLEAR takes priority over a same-cycle ENTER.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ENTRY: begin
        if (clear_p) begin
          state_d = IDLE;
        end else if (enter_p && !reject_s) begin
          state_d = (count_q == 3'(NUM_DIGITS - 1)) ? FULL : ENTRY;
        end else begin
          state_d = state_q;
        end
      end
      FULL: begin
        if (clear_p) begin
          state_d = IDLE;
        end else if (enter_p) begin
          state_d = OFFER;
        end else begin
          state_d = FULL;
        end
      end
      OFFER: begin
        if (word_if.word_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OFFER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic for the entry word, commit register and error pulse.
  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    word_d  = word_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE, ENTRY: begin
        if (clear_p) begin
          entry_d = {WORD_W{1'b0}};
          count_d = 3'd0;
        end else if (enter_p) begin
          if (reject_s) begin
            err_d = 1'b1;
          end else begin
            entry_d = append_digit(entry_q, digit_in);
            count_d = count_q + 3'd1;
          end
        end else begin
          err_d = 1'b0;
        end
      end
      FULL: begin
        if (clear_p) begin
          entry_d = {WORD_W{1'b0}};
          count_d = 3'd0;
        end else if (enter_p) begin
          word_d  = entry_q;
          valid_d = 1'b1;
          entry_d = {WORD_W{1'b0}};
          count_d = 3'd0;
        end else begin
          err_d = 1'b0;
        end
      end
      OFFER: begin
        // word_out is left untouched after the transfer so the last word stays visible.
        valid_d = ~word_if.word_ready;
        err_d   = enter_p | clear_p;
      end
      default: begin
        entry_d = {WORD_W{1'b0}};
        count_d = 3'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= {WORD_W{1'b0}};
      count_q <= 3'd0;
      word_q  <= {WORD_W{1'b0}};
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign word_if.word_out   = word_q;
  assign word_if.word_valid = valid_q;
  assign entry_value        = entry_q;
  assign digit_count        = count_q;
  assign entry_error        = err_q;

endmodule
